// File: rtl/mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mul_issue_ctrl
// Control stage in front of the radix-4 iterative multiplier used for the
// RV32M MUL / MULH / MULHSU / MULHU instructions. Holds exactly one operation
// at a time:
//   IDLE  -> accept a request from execute issue and latch its operands
//   ISSUE -> hand the operands and sign controls to the multiplier
//   WAIT  -> take the 64-bit product and keep the low or high word
//   DONE  -> present the registered result to writeback until accepted
// If either operand is zero and ZERO_BYPASS is set, the multiplier is skipped
// and a zero result goes straight to DONE. A flush cancels the op in any state.
//
// Ports
//   clock, reset (async, active-low), flush
//   req_*          : issue request (valid/ready, op, rs1, rs2, rd tag)
//   busy           : an op is in flight
//   mul_in_*       : operand handshake to the multiplier (sign[1]=rs1, [0]=rs2)
//   mul_out_*      : product handshake from the multiplier
//   mul_flush      : flush forwarded to the multiplier
//   wb_*           : registered result handshake to writeback
// ---------------------------------------------------------------------------
module mul_issue_ctrl #(
    parameter int ZERO_BYPASS = 1,
    parameter int TAG_W       = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_rd,
    output logic             busy,
    output logic             mul_in_valid,
    input  logic             mul_in_ready,
    output logic [1:0]       mul_in_sign,
    output logic [31:0]      mul_in_a,
    output logic [31:0]      mul_in_b,
    input  logic             mul_out_valid,
    output logic             mul_out_ready,
    input  logic [63:0]      mul_out_prod,
    output logic             mul_flush,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_rd
);

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULH   = 2'd1;
    localparam logic [1:0] OP_MULHSU = 2'd2;
    localparam logic [1:0] OP_MULHU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q,  state_d;
    logic [31:0]        rs1_q,    rs1_d;
    logic [31:0]        rs2_q,    rs2_d;
    logic [1:0]         op_q,     op_d;
    logic [TAG_W-1:0]   rd_q,     rd_d;
    logic [31:0]        result_q, result_d;

    logic               zero_operand;

    assign zero_operand = (ZERO_BYPASS != 0) && ((req_rs1 == 32'd0) || (req_rs2 == 32'd0));

    // Next-state and register update
    always_comb begin
        state_d  = state_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        op_d     = op_q;
        rd_d     = rd_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    rs1_d = req_rs1;
                    rs2_d = req_rs2;
                    op_d  = req_op;
                    rd_d  = req_rd;
                    if (zero_operand) begin
                        result_d = 32'd0;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!flush && mul_in_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mul_out_valid && !flush) begin
                    result_d = (op_q == OP_MUL) ? mul_out_prod[31:0] : mul_out_prod[63:32];
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!flush && wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over every handshake that would otherwise fire this cycle.
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            result_q <= result_d;
        end
    end

    // Sign controls only driven while offering the op, so they read 0 otherwise.
    always_comb begin
        mul_in_sign = 2'b00;
        if (state_q == ST_ISSUE) begin
            case (op_q)
                OP_MUL, OP_MULH: mul_in_sign = 2'b11;
                OP_MULHSU:       mul_in_sign = 2'b10;
                OP_MULHU:        mul_in_sign = 2'b00;
                default:         mul_in_sign = 2'b00;
            endcase
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign mul_in_valid  = (state_q == ST_ISSUE) && !flush;
    assign mul_in_a      = rs1_q;
    assign mul_in_b      = rs2_q;
    assign mul_out_ready = (state_q == ST_WAIT);
    assign mul_flush     = flush;
    assign wb_valid      = (state_q == ST_DONE) && !flush;
    assign wb_data       = result_q;
    assign wb_rd         = rd_q;

endmodule
